mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory
// between a CPU port and a DMA port, one 3-cycle access at a time.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_address,
  input  logic [7:0]    cpu_o_data,
  input  logic          cpu_wren,
  output logic [7:0]    cpu_i_data,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_address,
  input  logic [7:0]    dma_wdata,
  input  logic          dma_wren,
  output logic [7:0]    dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_address,
  output logic [7:0]    mem_wdata,
  output logic          mem_wren,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic          grant, grant_dma;
  logic          own_dma, last_dma, wren_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q, cpu_rd_q, dma_rd_q;

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_dma = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant     = 1'b1;
          // on a tie the port that did not win last time goes
          grant_dma = dma_req && (!cpu_req || !last_dma);
          state_nx  = ISSUE;
        end
      end
      ISSUE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      own_dma  <= 1'b0;
      last_dma <= CPU_FIRST;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        own_dma <= grant_dma;
        wren_q  <= grant_dma ? dma_wren : cpu_wren;
        addr_q  <= grant_dma ? dma_address : cpu_address;
        wdata_q <= grant_dma ? dma_wdata : cpu_o_data;
      end
      if (state == DONE) begin
        last_dma <= own_dma;
        if (!wren_q) begin
          if (own_dma) dma_rd_q <= mem_rdata;
          else         cpu_rd_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wren    = (state == ISSUE) && wren_q;
  assign cpu_ready   = (state == DONE) && !own_dma;
  assign dma_ack     = (state == DONE) && own_dma;

  // read data arrives in DONE, so pass it through while the pulse is up
  assign cpu_i_data = (cpu_ready && !wren_q) ? mem_rdata : cpu_rd_q;
  assign dma_rdata  = (dma_ack && !wren_q) ? mem_rdata : dma_rd_q;

endmodule
